// File: rtl/store_buffer_pkg.sv
// Shared processor definitions for the store buffer: the default depth and the
// entry layout used by the buffer storage.
package store_buffer_pkg;

    localparam int SB_DEPTH = 4;
    localparam int SB_XLEN  = 32;

    typedef struct packed {
        logic               valid;
        logic [SB_XLEN-1:0] addr;
        logic [SB_XLEN-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer.sv
// In-order word store buffer between the core memory stage and data memory,
// with zero-latency youngest-match load forwarding.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int WIDTH = SB_XLEN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemWriteM,
    input  logic [WIDTH-1:0] DataAdrM,
    input  logic [WIDTH-1:0] WriteDataM,
    output logic [WIDTH-1:0] ReadDataM,
    output logic             StallM,
    input  logic [WIDTH-1:0] RdData,
    output logic             WrEn,
    output logic [WIDTH-1:0] WrAdr,
    output logic [WIDTH-1:0] WrData,
    input  logic             WrReady,
    output logic             Empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    sb_entry_t        ent [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count;
    logic             full;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] st_adr;

    assign full   = (count == CW'(DEPTH));
    assign Empty  = (count == '0);
    assign StallM = MemWriteM & full;
    assign push   = MemWriteM & ~full;
    assign WrEn   = ~Empty;
    assign pop    = WrEn & WrReady;
    assign st_adr = {DataAdrM[WIDTH-1:2], 2'b00};
    assign WrAdr  = WIDTH'(ent[head].addr);
    assign WrData = WIDTH'(ent[head].data);

    // Walk from oldest to youngest so the last match seen is the youngest store.
    function automatic logic [WIDTH-1:0] youngest_match(
        input logic [PW-1:0]    hd,
        input logic [WIDTH-1:0] adr,
        input logic [WIDTH-1:0] mem
    );
        logic [WIDTH-1:0] res;
        logic [WIDTH-1:0] eadr;
        logic [PW-1:0]    idx;
        res = mem;
        for (int i = 0; i < DEPTH; i++) begin
            idx  = hd + PW'(i);
            eadr = WIDTH'(ent[idx].addr);
            if (ent[idx].valid && (((eadr ^ adr) & ~WIDTH'(3)) == '0)) begin
                res = WIDTH'(ent[idx].data);
            end
        end
        return res;
    endfunction

    always_comb begin
        ReadDataM = youngest_match(head, DataAdrM, RdData);
    end

    // Push and pop never target the same slot: that needs head==tail, i.e. full or empty.
    always_ff @(posedge clk) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent[i].valid <= 1'b0;
            end
        end else begin
            if (push) begin
                ent[tail].valid <= 1'b1;
                ent[tail].addr  <= SB_XLEN'(st_adr);
                ent[tail].data  <= SB_XLEN'(WriteDataM);
                tail            <= tail + PW'(1);
            end
            if (pop) begin
                ent[head].valid <= 1'b0;
                head            <= head + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: drain, fill/stall, forwarding, push+pop,
// reset mid-operation and misaligned stores.
module tb_store_buffer;

    logic        clk;
    logic        reset;
    logic        MemWriteM;
    logic [31:0] DataAdrM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic [31:0] RdData;
    logic        WrEn;
    logic [31:0] WrAdr;
    logic [31:0] WrData;
    logic        WrReady;
    logic        Empty;

    int checks   = 0;
    int failures = 0;

    store_buffer #(.DEPTH(4), .WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWriteM  (MemWriteM),
        .DataAdrM   (DataAdrM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .RdData     (RdData),
        .WrEn       (WrEn),
        .WrAdr      (WrAdr),
        .WrData     (WrData),
        .WrReady    (WrReady),
        .Empty      (Empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [31:0] adr, input logic [31:0] dat);
        MemWriteM  = we;
        DataAdrM   = adr;
        WriteDataM = dat;
        #1;
    endtask

    initial begin
        reset = 1'b0; MemWriteM = 1'b0; DataAdrM = '0; WriteDataM = '0;
        RdData = '0; WrReady = 1'b0;
        tick(); tick();
        #1;
        chk("rst_wren", {31'd0, WrEn}, 32'd0);
        chk("rst_empty", {31'd0, Empty}, 32'd1);
        chk("rst_stall", {31'd0, StallM}, 32'd0);
        reset = 1'b1;

        // single store and drain
        WrReady = 1'b1;
        drive(1'b1, 32'h0000_0104, 32'hDEAD_BEEF);
        chk("t1_no_early_wren", {31'd0, WrEn}, 32'd0);
        chk("t1_stall", {31'd0, StallM}, 32'd0);
        tick();
        RdData = 32'h1111_1111;
        drive(1'b0, 32'h0000_0104, 32'h0);
        chk("t1_wren", {31'd0, WrEn}, 32'd1);
        chk("t1_wradr", WrAdr, 32'h0000_0104);
        chk("t1_wrdata", WrData, 32'hDEAD_BEEF);
        chk("t1_fwd_popping", ReadDataM, 32'hDEAD_BEEF);
        tick();
        #1;
        chk("t1_empty", {31'd0, Empty}, 32'd1);
        chk("t1_wren_off", {31'd0, WrEn}, 32'd0);
        chk("t1_rd_mem", ReadDataM, 32'h1111_1111);

        // fill and stall
        WrReady = 1'b0;
        drive(1'b1, 32'h10, 32'hA0); chk("t2_stall0", {31'd0, StallM}, 32'd0); tick();
        drive(1'b1, 32'h14, 32'hA1); chk("t2_stall1", {31'd0, StallM}, 32'd0); tick();
        drive(1'b1, 32'h18, 32'hA2); chk("t2_stall2", {31'd0, StallM}, 32'd0); tick();
        drive(1'b1, 32'h1C, 32'hA3); chk("t2_stall3", {31'd0, StallM}, 32'd0); tick();
        drive(1'b1, 32'h20, 32'hA4); chk("t2_stall4", {31'd0, StallM}, 32'd1); tick();
        #1;
        chk("t2_stall_hold", {31'd0, StallM}, 32'd1);
        chk("t2_head_hold", WrAdr, 32'h10);
        WrReady = 1'b1;
        #1;
        chk("t2_stall_pop", {31'd0, StallM}, 32'd1);
        chk("t2_wr0", WrAdr, 32'h10);
        tick();
        #1;
        chk("t2_stall_rel", {31'd0, StallM}, 32'd0);
        chk("t2_wr1", WrAdr, 32'h14);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        chk("t2_wr2", WrAdr, 32'h18);
        tick(); #1;
        chk("t2_wr3", WrAdr, 32'h1C);
        tick(); #1;
        chk("t2_wr4_adr", WrAdr, 32'h20);
        chk("t2_wr4_dat", WrData, 32'hA4);
        tick(); #1;
        chk("t2_empty", {31'd0, Empty}, 32'd1);

        // forwarding priority and no self-forwarding
        WrReady = 1'b0;
        drive(1'b1, 32'h40, 32'h1); tick();
        drive(1'b1, 32'h40, 32'h2); tick();
        RdData = 32'h77;
        drive(1'b0, 32'h42, 32'h0);
        chk("t3_fwd_young", ReadDataM, 32'h2);
        drive(1'b0, 32'h44, 32'h0);
        chk("t3_fwd_miss", ReadDataM, 32'h77);
        RdData = 32'h55;
        drive(1'b1, 32'h48, 32'h9);
        chk("t3_no_self_fwd", ReadDataM, 32'h55);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        WrReady = 1'b1;
        #1;
        chk("t3_order0", WrData, 32'h1);
        tick(); #1;
        chk("t3_order1", WrData, 32'h2);
        tick(); #1;
        chk("t3_order2", WrAdr, 32'h48);
        tick(); #1;
        chk("t3_empty", {31'd0, Empty}, 32'd1);

        // simultaneous push and pop with two entries buffered
        WrReady = 1'b0;
        drive(1'b1, 32'h60, 32'hB0); tick();
        drive(1'b1, 32'h64, 32'hB1); tick();
        WrReady = 1'b1;
        drive(1'b1, 32'h68, 32'hB2);
        chk("t4_stall0", {31'd0, StallM}, 32'd0); chk("t4_wr0", WrAdr, 32'h60); tick();
        drive(1'b1, 32'h6C, 32'hB3);
        chk("t4_stall1", {31'd0, StallM}, 32'd0); chk("t4_wr1", WrAdr, 32'h64); tick();
        drive(1'b1, 32'h70, 32'hB4);
        chk("t4_stall2", {31'd0, StallM}, 32'd0); chk("t4_wr2", WrAdr, 32'h68); tick();
        drive(1'b0, 32'h0, 32'h0);
        chk("t4_wr3", WrAdr, 32'h6C);
        tick(); #1;
        chk("t4_wr4", WrAdr, 32'h70);
        chk("t4_wr4_dat", WrData, 32'hB4);
        tick(); #1;
        chk("t4_empty_occ2", {31'd0, Empty}, 32'd1);

        // reset mid-operation discards buffered stores
        WrReady = 1'b0;
        drive(1'b1, 32'h80, 32'hC0); tick();
        drive(1'b1, 32'h84, 32'hC1); tick();
        drive(1'b1, 32'h88, 32'hC2); tick();
        drive(1'b0, 32'h0, 32'h0);
        chk("t5_pre_wren", {31'd0, WrEn}, 32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        chk("t5_wren", {31'd0, WrEn}, 32'd0);
        chk("t5_empty", {31'd0, Empty}, 32'd1);
        chk("t5_stall", {31'd0, StallM}, 32'd0);
        WrReady = 1'b1;
        RdData  = 32'h33;
        drive(1'b0, 32'h80, 32'h0);
        chk("t5_no_fwd", ReadDataM, 32'h33);
        tick(); tick(); #1;
        chk("t5_no_writes", {31'd0, WrEn}, 32'd0);

        // misaligned store is word aligned
        WrReady = 1'b0;
        drive(1'b1, 32'h103, 32'hA5A5_A5A5); tick();
        RdData = 32'h0;
        drive(1'b0, 32'h101, 32'h0);
        chk("t6_wradr", WrAdr, 32'h100);
        chk("t6_wrdata", WrData, 32'hA5A5_A5A5);
        chk("t6_fwd", ReadDataM, 32'hA5A5_A5A5);
        WrReady = 1'b1;
        tick(); #1;
        chk("t6_empty", {31'd0, Empty}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
